// File: rtl/brg_frac.sv
// Fractional baud-rate generator: divides clk by BaudRate + BaudFrac/2^FRAC_W to produce an
// oversample tick, then counts OSR of those for the mid-bit and bit-rate ticks.
module brg_frac #(
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned FRAC_W = 4,
    parameter int unsigned OSR    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              restart,
    input  logic [DIV_W-1:0]  BaudRate,
    input  logic [FRAC_W-1:0] BaudFrac,
    output logic              os_tick,
    output logic              half_tick,
    output logic              indicator,
    output logic              cfg_err
);

    localparam int unsigned        OSC_W    = $clog2(OSR);
    localparam logic [OSC_W-1:0]   OSC_HALF = OSC_W'(OSR / 2 - 1);
    localparam logic [OSC_W-1:0]   OSC_LAST = OSC_W'(OSR - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]        state;
    logic [DIV_W-1:0]  cnt;
    logic [FRAC_W-1:0] acc;
    logic [OSC_W-1:0]  osc;

    logic [FRAC_W-1:0] acc_base;
    logic [FRAC_W:0]   acc_sum;
    logic              clamp;
    logic [DIV_W-1:0]  div;
    logic [DIV_W-1:0]  cnt_load;

    // Load-time arithmetic; the accumulator carry stretches this period by one cycle.
    always_comb begin
        acc_base = (state == RUN) ? acc : '0;
        acc_sum  = {1'b0, acc_base} + {1'b0, BaudFrac};
        clamp    = BaudRate < DIV_W'(2);
        div      = clamp ? DIV_W'(2) : BaudRate;
        cnt_load = div - DIV_W'(1) + DIV_W'(acc_sum[FRAC_W]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            osc       <= '0;
            os_tick   <= 1'b0;
            half_tick <= 1'b0;
            indicator <= 1'b0;
            cfg_err   <= 1'b0;
        end else if (restart || (state == RUN && !en)) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            osc       <= '0;
            os_tick   <= 1'b0;
            half_tick <= 1'b0;
            indicator <= 1'b0;
            cfg_err   <= 1'b0;
        end else if (state == IDLE) begin
            if (en) begin
                state   <= RUN;
                cnt     <= cnt_load;
                acc     <= acc_sum[FRAC_W-1:0];
                cfg_err <= clamp;
            end
        end else if (cnt != '0) begin
            cnt       <= cnt - DIV_W'(1);
            os_tick   <= 1'b0;
            half_tick <= 1'b0;
            indicator <= 1'b0;
        end else begin
            cnt       <= cnt_load;
            acc       <= acc_sum[FRAC_W-1:0];
            cfg_err   <= clamp;
            os_tick   <= 1'b1;
            half_tick <= (osc == OSC_HALF);
            indicator <= (osc == OSC_LAST);
            osc       <= (osc == OSC_LAST) ? '0 : osc + OSC_W'(1);
        end
    end

endmodule

// File: tb/tb_brg_frac.sv
// Bench for brg_frac: per-cycle comparison against an event-time model, plus directed
// tick-spacing checks with literal expected edge counts.
module tb_brg_frac;

    localparam int unsigned DIV_W  = 16;
    localparam int unsigned FRAC_W = 4;
    localparam int unsigned OSR    = 16;
    localparam int          FMOD   = 1 << FRAC_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              en = 1'b0;
    logic              restart = 1'b0;
    logic [DIV_W-1:0]  BaudRate = '0;
    logic [FRAC_W-1:0] BaudFrac = '0;
    logic              os_tick, half_tick, indicator, cfg_err;

    brg_frac #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .OSR(OSR)) dut (
        .clk(clk), .rst(rst), .en(en), .restart(restart),
        .BaudRate(BaudRate), .BaudFrac(BaudFrac),
        .os_tick(os_tick), .half_tick(half_tick), .indicator(indicator), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int os_q[$];
    int half_q[$];
    int ind_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: absolute edge number of the next tick, fractional accumulator and tick count.
    int  m_now = 0;
    bit  m_run = 0;
    int  m_next = 0;
    int  m_acc = 0;
    int  m_ticks = 0;
    bit  e_os = 0, e_half = 0, e_ind = 0, e_err = 0;

    task automatic model_load();
        int br, div, carry;
        br     = int'(BaudRate);
        div    = (br < 2) ? 2 : br;
        m_acc  = m_acc + int'(BaudFrac);
        carry  = (m_acc >= FMOD) ? 1 : 0;
        m_acc  = m_acc % FMOD;
        m_next = m_now + div + carry;
        e_err  = (br < 2);
    endtask

    task automatic model_step();
        int idx;
        m_now++;
        e_os = 0; e_half = 0; e_ind = 0;
        if (!rst || restart || (m_run && !en)) begin
            m_run = 0; m_acc = 0; m_ticks = 0; e_err = 0;
        end else if (!m_run) begin
            if (en) begin
                m_run = 1; m_acc = 0; m_ticks = 0;
                model_load();
            end
        end else if (m_now == m_next) begin
            idx     = m_ticks % OSR;
            e_os    = 1;
            e_half  = (idx == OSR / 2 - 1);
            e_ind   = (idx == OSR - 1);
            m_ticks++;
            model_load();
        end
    endtask

    // Model step on the edge, compare and record tick times just after it.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            chk("outputs{os,half,ind,err}", {os_tick, half_tick, indicator, cfg_err},
                {e_os, e_half, e_ind, e_err});
            if (os_tick)   os_q.push_back(cyc);
            if (half_tick) half_q.push_back(cyc);
            if (indicator) ind_q.push_back(cyc);
        end
    end

    function automatic int qsize(input int which);
        case (which)
            0:       return os_q.size();
            1:       return half_q.size();
            default: return ind_q.size();
        endcase
    endfunction

    function automatic int qget(input int which, input int i);
        if (i >= qsize(which)) return -1;
        case (which)
            0:       return os_q[i];
            1:       return half_q[i];
            default: return ind_q[i];
        endcase
    endfunction

    task automatic wait_n(input int which, input int n, input int budget, input string name);
        for (int i = 0; i < budget && qsize(which) < n; i++) @(negedge clk);
        chk(name, qsize(which), n);
    endtask

    task automatic start_run(input int br, input int bf, output int e0);
        @(negedge clk);
        en = 1'b0; restart = 1'b0;
        BaudRate = DIV_W'(br); BaudFrac = FRAC_W'(bf);
        @(negedge clk);
        os_q.delete(); half_q.delete(); ind_q.delete();
        en = 1'b1;
        @(posedge clk);
        #1 e0 = cyc;
    endtask

    initial begin
        int e0, target;
        bit seen;

        #12;
        chk("reset_outputs", {os_tick, half_tick, indicator, cfg_err}, 0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("idle_outputs", {os_tick, half_tick, indicator, cfg_err}, 0);

        // Integer divisor.
        start_run(130, 0, e0);
        wait_n(2, 2, 4400, "int_ind_timeout");
        chk("int_first_os", qget(0, 0), e0 + 130);
        chk("int_os_spacing", qget(0, 1) - qget(0, 0), 130);
        chk("int_first_half", qget(1, 0), e0 + 1040);
        chk("int_first_ind", qget(2, 0), e0 + 2080);
        chk("int_ind_spacing", qget(2, 1) - qget(2, 0), 2080);
        chk("int_cfg_err", cfg_err, 0);

        // Fractional divisor 10 + 4/16.
        start_run(10, 4, e0);
        wait_n(2, 2, 400, "frac_ind_timeout");
        chk("frac_p0", qget(0, 0) - e0, 10);
        chk("frac_p1", qget(0, 1) - qget(0, 0), 10);
        chk("frac_p2", qget(0, 2) - qget(0, 1), 10);
        chk("frac_p3", qget(0, 3) - qget(0, 2), 11);
        chk("frac_16_ticks", qget(0, 16) - qget(0, 0), 164);
        chk("frac_first_ind", qget(2, 0), e0 + 164);
        chk("frac_ind_spacing", qget(2, 1) - qget(2, 0), 164);

        // Divisor change 50 cycles into a period.
        start_run(130, 0, e0);
        wait_n(0, 1, 200, "chg_first_timeout");
        repeat (50) @(negedge clk);
        BaudRate = DIV_W'(65);
        wait_n(0, 4, 400, "chg_timeout");
        chk("chg_cur_period", qget(0, 1) - qget(0, 0), 130);
        chk("chg_next_period", qget(0, 2) - qget(0, 1), 65);
        chk("chg_after_period", qget(0, 3) - qget(0, 2), 65);

        // Restart mid-bit.
        start_run(130, 0, e0);
        wait_n(0, 10, 1500, "rs_timeout");
        @(negedge clk); restart = 1'b1;
        @(posedge clk); #1;
        chk("rs_ticks_cleared", {os_tick, half_tick, indicator}, 0);
        @(negedge clk); restart = 1'b0;
        os_q.delete(); half_q.delete(); ind_q.delete();
        @(posedge clk); #1 e0 = cyc;
        wait_n(2, 1, 2200, "rs_ind_timeout");
        chk("rs_first_ind", qget(2, 0), e0 + 2080);

        // Disable on the edge that would have ticked.
        start_run(130, 0, e0);
        wait_n(0, 2, 400, "dis_timeout");
        target = qget(0, 1) + 129;
        for (int i = 0; i < 300 && cyc != target; i++) @(negedge clk);
        en = 1'b0;
        @(posedge clk); #1;
        chk("dis_no_tick", {os_tick, half_tick, indicator}, 0);

        // Asynchronous reset while os_tick is high.
        start_run(130, 0, e0);
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(posedge clk); #1;
            seen = os_tick;
        end
        chk("arst_saw_tick", seen, 1);
        #2 rst = 1'b0;
        #1 chk("arst_immediate", {os_tick, half_tick, indicator, cfg_err}, 0);
        @(negedge clk); @(negedge clk); rst = 1'b1;
        start_run(130, 0, e0);
        wait_n(0, 1, 200, "reen_timeout");
        chk("reen_first_os", qget(0, 0), e0 + 130);

        // Clamp of 0 and 1, then recovery.
        for (int b = 0; b < 2; b++) begin
            start_run(b, 0, e0);
            wait_n(0, 3, 20, "clamp_timeout");
            chk("clamp_first_os", qget(0, 0), e0 + 2);
            chk("clamp_spacing", qget(0, 2) - qget(0, 1), 2);
            chk("clamp_cfg_err", cfg_err, 1);
        end
        BaudRate = DIV_W'(5);
        repeat (3) @(negedge clk);
        chk("clamp_cleared", cfg_err, 0);

        // Randomised traffic, checked every cycle against the model.
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            restart = ($urandom_range(0, 299) == 0);
            if (!rst) rst = 1'b1;
            else if ($urandom_range(0, 1499) == 0) rst = 1'b0;
            if (en) en = ($urandom_range(0, 399) != 0);
            else    en = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 49) == 0) begin
                BaudRate = ($urandom_range(0, 9) == 0) ? DIV_W'($urandom_range(0, 40))
                                                       : DIV_W'($urandom_range(0, 12));
                BaudFrac = FRAC_W'($urandom_range(0, FMOD - 1));
            end
        end
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/brg_frac.md
# brg_frac

Parametrised fractional baud-rate generator, successor to `brg`. Divides `clk` by a programmable integer-plus-fraction divisor to produce an oversampling tick (`os_tick`), then counts `OSR` oversampling ticks to produce the bit-rate tick (`indicator`) and a mid-bit sampling tick (`half_tick`). It feeds the UART transmitter (bit strobe) and receiver (oversample and mid-bit strobes). A new divisor takes effect at a period boundary, so a running tick stream never glitches.

## Interface
- `DIV_W`, 16: width of the integer divisor.
- `FRAC_W`, 4: width of the fractional divisor, in units of 1/2^FRAC_W.
- `OSR`, 16: oversampling ratio. Even, ≥ 2.

- `clk`  in  1: system clock.
- `rst`  in  1: reset, asynchronous, active-low.
- `en`  in  1: run enable, level-sensitive.
- `restart`  in  1: synchronous phase restart, one-cycle pulse.
- `BaudRate`  in  DIV_W: integer oversample period, in clk cycles.
- `BaudFrac`  in  FRAC_W: fractional part of the oversample period.
- `os_tick`  out  1: oversample tick, 1-cycle pulse.
- `half_tick`  out  1: mid-bit tick, 1-cycle pulse.
- `indicator`  out  1: bit-rate tick, 1-cycle pulse.
- `cfg_err`  out  1: latched divisor was clamped.

## Operation
- State machine with two states, IDLE and RUN.
- Internal registers:
  - `cnt` (DIV_W bits): period down-counter.
  - `acc` (FRAC_W bits): fractional accumulator.
  - `osc` (0..OSR-1): oversample index.
- Load action, performed on the start edge and at every reload:
  - Sample `BaudRate` and `BaudFrac`.
  - `{carry, acc} <= acc + BaudFrac`.
  - `div = max(BaudRate, 2)`.
  - Period `P = div + carry`.
  - `cnt <= P - 1`.
  - `cfg_err <= (BaudRate < 2)`.
- IDLE:
  - `cnt`, `acc`, `osc` and all tick outputs are 0.
  - An edge with `en=1` and `restart=0` performs the load action with `acc` starting from 0, then moves to RUN.
- RUN, on each edge:
  - `cnt != 0`: `cnt` decrements; all ticks go to 0.
  - `cnt == 0`:
    - `os_tick <= 1` and the load action is performed (reload).
    - `half_tick <= (osc == OSR/2-1)`.
    - `indicator <= (osc == OSR-1)`.
    - `osc` increments, wrapping OSR-1 → 0.
- Average oversample period is `BaudRate + BaudFrac/2^FRAC_W` cycles. Carries are spread evenly by the accumulator.
- Divisor changes are sampled only at load, so a change made mid-period affects the next period only.
- `en=0` in RUN: next edge goes to IDLE and clears all counters and outputs. There is no pause/resume.
- `restart=1` in any state: next edge goes to IDLE (same clearing). `restart` has priority over `en`. A new start requires an edge with `restart=0`, `en=1`.
- Asynchronous reset (`rst=0`):
  - Immediately forces IDLE, `cnt=acc=osc=0`, `os_tick=half_tick=indicator=cfg_err=0`.
  - Takes effect mid-period with no pending tick emitted.

## Timing
- All outputs are registered.
- Reset value of every output: 0.
- The start edge (first edge in IDLE with `en=1`) is E0. The first `os_tick` is high in the cycle after edge E0+P0.
- Each following `os_tick` comes P_i edges after the previous one. `os_tick` always lasts exactly one cycle, and the minimum spacing is 2 cycles.
- `half_tick` coincides with the (OSR/2)-th `os_tick` of each bit. `indicator` coincides with the OSR-th.
- Both are always concurrent with `os_tick`, never alone.
- `cfg_err` updates on each load and holds between loads.

## Test plan
- **Integer divisor:** OSR=16, BaudRate=130, BaudFrac=0, `en` held 1.
  - `os_tick` every 130 cycles.
  - First `half_tick` 1040 edges after E0.
  - `indicator` every 2080 cycles.
  - `cfg_err=0`.
- **Fractional divisor:** FRAC_W=4, BaudRate=10, BaudFrac=4.
  - Periods repeat 10,10,10,11.
  - 16 `os_tick` in 164 cycles.
  - `indicator` every 164 cycles.
- **Mid-period change:** BaudRate changed 130→65 after 50 cycles of a period.
  - Current period completes at 130.
  - All following periods are 65.
  - No extra or missing tick.
- **Restart:** `restart` pulsed mid-bit with `en=1`.
  - All ticks 0 the next cycle; `osc` cleared.
  - Next `indicator` 16×130 edges after the restart-release start edge.
- **Disable and reset:**
  - `en` dropped mid-run: outputs 0 from the next edge.
  - `rst` pulsed low mid-run: outputs 0 immediately, asynchronously.
  - Re-enable: first `os_tick` P0 edges later.
- **Clamp:** BaudRate=0 and BaudRate=1 with BaudFrac=0.
  - `os_tick` every 2 cycles.
  - `cfg_err=1`.
  - Setting BaudRate=5 clears `cfg_err` at the next load.
